// File: rtl/obi_sram_arbiter.sv
// Shared single-port data SRAM behind NUM_MASTERS OBI request ports.
// Per-cycle arbitration, round-robin or fixed priority, fixed 1-cycle response.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_i / gnt_o     per-port request and same-cycle combinational grant
//   addr_i, we_i      per-port byte address and write flag (port k in slice k)
//   be_i, wdata_i     per-port byte enables and write data
//   rvalid_o          per-port response valid, one cycle after the grant
//   rdata_o, err_o    shared response data / out-of-range error, qualified by rvalid_o
//   busy_o            a response is being presented this cycle
module obi_sram_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          MEM_SIZE_BYTES = 8192,
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter int          ARB_MODE       = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_MASTERS-1:0]               req_i,
    output logic [NUM_MASTERS-1:0]               gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_MASTERS-1:0]               we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_MASTERS-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 err_o,
    output logic                                 busy_o
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int BYTE_BITS = (NB > 1) ? $clog2(NB) : 0;
    localparam int WORDS     = MEM_SIZE_BYTES / NB;
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    // One extra bit so a window as large as the address space still compares.
    localparam logic [ADDR_WIDTH:0]   SIZE = (ADDR_WIDTH+1)'(MEM_SIZE_BYTES);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] sel;
    logic             any;
    int               cand;

    // The search starts at the pointer; in fixed-priority mode the pointer
    // is tied to zero, so the same search yields lowest-index-wins.
    always_comb begin
        sel  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (int'(ptr_q) + i) % NUM_MASTERS;
            if (!any && req_i[cand]) begin
                any = 1'b1;
                sel = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any) begin
            gnt_o[sel] = 1'b1;
        end
    end

    generate
        if (ARB_MODE == 0 && NUM_MASTERS > 1) begin : g_rr
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ptr_q <= '0;
                end else if (any) begin
                    if (int'(sel) == NUM_MASTERS - 1) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= sel + 1'b1;
                    end
                end
            end
        end else begin : g_fixed
            assign ptr_q = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Granted request and address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_we;
    logic [NB-1:0]         s_be;
    logic [DATA_WIDTH-1:0] s_wdata;

    assign s_addr  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we    = we_i[sel];
    assign s_be    = be_i[int'(sel)*NB +: NB];
    assign s_wdata = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign off      = s_addr - BASE;
    assign in_range = (s_addr >= BASE) && ({1'b0, off} < SIZE);
    // Byte-offset bits are dropped; off < SIZE keeps the index in range.
    assign idx      = IDX_W'(off >> BYTE_BITS);

    logic do_wr;
    logic do_rd;

    assign do_wr = any && in_range && s_we;
    assign do_rd = any && in_range && !s_we;

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (s_be[b]) begin
                    mem[idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] rvalid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;

    // rdata is zeroed for errors and writes so a stale word never leaks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt_o;
            err_q    <= any && !in_range;
            rdata_q  <= do_rd ? mem[idx] : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign busy_o   = |rvalid_q;

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Bench for obi_sram_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream; a behavioural model checks both every cycle.
module tb_obi_sram_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int SIZE = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    we;
    logic [N*NB-1:0] be;
    logic [N*DW-1:0] wdata;

    logic [N-1:0]  gnt_rr, gnt_fp, rv_rr, rv_fp;
    logic [DW-1:0] rd_rr, rd_fp;
    logic          err_rr, err_fp, busy_rr, busy_fp;

    always #5 clk = ~clk;

    obi_sram_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_SIZE_BYTES(SIZE), .BASE_ADDR(BASE), .ARB_MODE(0)
    ) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_rr),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rv_rr), .rdata_o(rd_rr), .err_o(err_rr), .busy_o(busy_rr)
    );

    obi_sram_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_SIZE_BYTES(SIZE), .BASE_ADDR(BASE), .ARB_MODE(1)
    ) u_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_fp),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rv_fp), .rdata_o(rd_fp), .err_o(err_fp), .busy_o(busy_fp)
    );

    logic [N-1:0]  a_gnt [2];
    logic [N-1:0]  a_rv  [2];
    logic [DW-1:0] a_rd  [2];
    logic          a_err [2];
    logic          a_busy[2];

    assign a_gnt[0] = gnt_rr;  assign a_gnt[1] = gnt_fp;
    assign a_rv[0]  = rv_rr;   assign a_rv[1]  = rv_fp;
    assign a_rd[0]  = rd_rr;   assign a_rd[1]  = rd_fp;
    assign a_err[0] = err_rr;  assign a_err[1] = err_fp;
    assign a_busy[0] = busy_rr; assign a_busy[1] = busy_fp;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdata [int];
    logic [3:0]  mknown[int];

    int          ptr_m[2];
    bit          pv   [2];
    int          pport[2];
    bit          perr [2];
    logic [31:0] pdata[2];
    logic [31:0] pmask[2];

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{k[b]}};
        return r;
    endfunction

    // Mode 0 rotates the priority list to start at the pointer;
    // mode 1 always scans from port 0.
    function automatic int pick(input int mode, input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mode == 0) ? (p + k) % N : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] erv;
        logic [N-1:0] eg;
        logic [31:0]  a;
        int           c;
        int           w;
        bit           inr;
        bit           wr_pend;
        int           wr_w;
        logic [3:0]   wr_be;
        logic [31:0]  wr_d;
        wr_pend = 1'b0;
        wr_w = 0;
        wr_be = '0;
        wr_d = '0;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                check($sformatf("m%0d_rst_rvalid", m), a_rv[m], 0);
                check($sformatf("m%0d_rst_err", m), a_err[m], 0);
                check($sformatf("m%0d_rst_rdata", m), a_rd[m], 0);
                check($sformatf("m%0d_rst_busy", m), a_busy[m], 0);
                ptr_m[m] = 0;
                pv[m] = 1'b0;
            end else begin
                erv = '0;
                if (pv[m]) erv[pport[m]] = 1'b1;
                check($sformatf("m%0d_rvalid", m), a_rv[m], erv);
                check($sformatf("m%0d_busy", m), a_busy[m], pv[m]);
                if (pv[m]) begin
                    check($sformatf("m%0d_err", m), a_err[m], perr[m]);
                    if (pmask[m] != 0)
                        check($sformatf("m%0d_rdata", m),
                              a_rd[m] & pmask[m], pdata[m] & pmask[m]);
                end
                c = pick(m, ptr_m[m], req);
                eg = '0;
                if (c >= 0) eg[c] = 1'b1;
                check($sformatf("m%0d_gnt", m), a_gnt[m], eg);
                pv[m] = (c >= 0);
                if (c >= 0) begin
                    a = addr[c*AW +: AW];
                    inr = (a >= BASE) && ((a - BASE) < SIZE);
                    w = int'((a - BASE) >> 2);
                    pport[m] = c;
                    perr[m] = !inr;
                    pdata[m] = '0;
                    pmask[m] = '0;
                    if (!inr) begin
                        pmask[m] = '1;
                    end else if (!we[c]) begin
                        if (mknown.exists(w)) begin
                            pdata[m] = mdata[w];
                            pmask[m] = bmask(mknown[w]);
                        end
                    end else if (m == 0) begin
                        wr_pend = 1'b1;
                        wr_w = w;
                        wr_be = be[c*NB +: NB];
                        wr_d = wdata[c*DW +: DW];
                    end
                    if (m == 0) ptr_m[m] = (c + 1) % N;
                end
            end
        end
        if (wr_pend) begin
            if (!mknown.exists(wr_w)) begin
                mdata[wr_w] = '0;
                mknown[wr_w] = '0;
            end
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mdata[wr_w][b*8 +: 8] = wr_d[b*8 +: 8];
                    mknown[wr_w][b] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input bit w, input logic [31:0] ad,
                       input logic [3:0] b, input logic [31:0] d);
        req[p] = 1'b1;
        we[p] = w;
        addr[p*AW +: AW] = ad;
        be[p*NB +: NB] = b;
        wdata[p*DW +: DW] = d;
    endtask

    logic [N-1:0] rr_order[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // write then read
        put(0, 1'b1, 32'h0001_0010, 4'hF, 32'hDEADBEEF);
        #1 check("t1_wr_gnt", gnt_rr, 3'b001);
        tick();
        check("t1_wr_rvalid", rv_rr, 3'b001);
        put(0, 1'b0, 32'h0001_0010, 4'hF, 32'h0);
        tick();
        req = '0;
        #1 check("t1_rd_rvalid", rv_rr, 3'b001);
        check("t1_rd_data", rd_rr, 32'hDEADBEEF);
        check("t1_rd_err", err_rr, 1'b0);

        // byte enables
        tick();
        put(0, 1'b1, 32'h0001_0020, 4'hF, 32'h11223344);
        tick();
        put(0, 1'b1, 32'h0001_0020, 4'b0101, 32'hAABBCCDD);
        tick();
        put(0, 1'b0, 32'h0001_0020, 4'hF, 32'h0);
        tick();
        req = '0;
        #1 check("t2_be_data", rd_fp, 32'h11BB33DD);

        // out of range, plus an out-of-range write that would alias 0x10010
        tick();
        put(0, 1'b0, 32'h0001_2000, 4'hF, 32'h0);
        tick();
        check("t5_hi_err", err_rr, 1'b1);
        check("t5_hi_rdata", rd_rr, 32'h0);
        put(0, 1'b0, 32'h0000_FFFC, 4'hF, 32'h0);
        tick();
        check("t5_lo_err", err_fp, 1'b1);
        check("t5_lo_rvalid", rv_fp, 3'b001);
        put(0, 1'b1, 32'h0001_2010, 4'hF, 32'h0);
        tick();
        check("t5_wr_err", err_rr, 1'b1);
        put(0, 1'b0, 32'h0001_0010, 4'hF, 32'h0);
        tick();
        req = '0;
        #1 check("t5_unmod", rd_rr, 32'hDEADBEEF);

        // reset one cycle after a read grant; port 0 grant moves RR pointer to 1
        tick();
        put(0, 1'b0, 32'h0001_0020, 4'hF, 32'h0);
        tick();
        req = '0;
        rst_n = 1'b0;
        #1 check("t6_rvalid_drop", rv_rr, 3'b000);
        check("t6_busy_drop", busy_rr, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;

        // round-robin fairness, all three ports reading
        put(0, 1'b0, 32'h0001_0010, 4'hF, 32'h0);
        put(1, 1'b0, 32'h0001_0020, 4'hF, 32'h0);
        put(2, 1'b0, 32'h0001_0030, 4'hF, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("t3_rr_gnt%0d", i), gnt_rr, rr_order[i]);
            check($sformatf("t3_fp_gnt%0d", i), gnt_fp, 3'b001);
            tick();
        end

        // fixed priority: ports 0 and 2 contend
        req[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t4_fp_p0_%0d", i), gnt_fp, 3'b001);
            tick();
        end
        req[0] = 1'b0;
        #1 check("t4_fp_p2", gnt_fp, 3'b100);
        tick();
        req = '0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
